// File: rtl/adder_share_arbiter.sv
// ---------------------------------------------------------------------------
// adder_share_arbiter
//
// Two requesters share one pipelined WIDTH-bit add datapath. Each cycle, a
// combinational grant selects at most one requester. The operation it issues
// enters the pipeline with a one-bit owner tag. The completed sum is then
// returned to that owner as a one-cycle rsp pulse, with no backpressure.
//
// Parameters
//   WIDTH  operand width; the sum is WIDTH+1 bits wide
//   LAT    edges from the accepting edge to the rsp pulse (legal range 2..8)
//
// Ports
//   clk                  rising-edge clock
//   rstn                 asynchronous active-low reset
//   req0_valid/ready     requester 0 handshake
//   req0_a/b/cin         requester 0 operands
//   req1_valid/ready     requester 1 handshake
//   req1_a/b/cin         requester 1 operands
//   rsp0_valid           rsp_sum belongs to requester 0 (pulse)
//   rsp1_valid           rsp_sum belongs to requester 1 (pulse)
//   rsp_sum              a+b+cin of the completing op; holds between pulses
//   busy                 registered: at least one op is in flight
//
// Configuration macro
//   ADDARB_FIXED_PRIO_EN  defined: requester 0 always wins a contended
//                         cycle and there is no round-robin pointer.
//                         undefined (default): round robin.
//
// Pipeline layout (an op accepted at edge n):
//   stage 0 (edge n)     captured a, b, cin, tag
//   stage 1 (edge n+1)   low-half sum + registered low carry, high operands
//   stage 2 (edge n+2)   full WIDTH+1 sum
//   stage k (edge n+k)   delay copies up to stage LAT, which drives the outputs
// ---------------------------------------------------------------------------
module adder_share_arbiter #(
  parameter int WIDTH = 28,
  parameter int LAT   = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH:0]   rsp_sum,
  output logic             busy
);

  localparam int LO_W = WIDTH / 2;
  localparam int HI_W = WIDTH - LO_W;

  logic ready0;
  logic ready1;
  logic acc0;
  logic acc1;
  logic acc_any;

  // -------------------------------------------------------------------------
  // Grant / ready. Only one ready can be high in a cycle. When no requester
  // is valid, ready points at the favoured requester, so a newly arriving
  // op from that side is accepted without waiting.
  // -------------------------------------------------------------------------
`ifdef ADDARB_FIXED_PRIO_EN
  always_comb begin
    ready0 = rstn & (req0_valid | ~req1_valid);
    ready1 = rstn & req1_valid & ~req0_valid;
  end
`else
  logic rr_q;

  always_comb begin
    ready0 = 1'b0;
    ready1 = 1'b0;
    if (rstn) begin
      if (!rr_q) begin
        ready0 = req0_valid | ~req1_valid;
        ready1 = req1_valid & ~req0_valid;
      end else begin
        ready0 = req0_valid & ~req1_valid;
        ready1 = req1_valid | ~req0_valid;
      end
    end
  end

  // After an accept, the pointer moves to the requester that was not granted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_q <= 1'b0;
    end else if (acc0) begin
      rr_q <= 1'b1;
    end else if (acc1) begin
      rr_q <= 1'b0;
    end
  end
`endif

  assign req0_ready = ready0;
  assign req1_ready = ready1;
  assign acc0       = req0_valid & ready0;
  assign acc1       = req1_valid & ready1;
  assign acc_any    = acc0 | acc1;

  // -------------------------------------------------------------------------
  // Pipeline
  // -------------------------------------------------------------------------
  logic [LAT:0]      v_q;
  logic [LAT:0]      tag_q;

  logic [WIDTH-1:0]  s0_a;
  logic [WIDTH-1:0]  s0_b;
  logic              s0_cin;

  logic [LO_W-1:0]   s1_lo;
  logic              s1_c;
  logic [HI_W-1:0]   s1_ha;
  logic [HI_W-1:0]   s1_hb;

  logic [WIDTH:0]    sum_q [2:LAT];

  logic [LO_W:0]     lo_full;
  logic [HI_W:0]     hi_full;

  assign lo_full = {1'b0, s0_a[LO_W-1:0]} + {1'b0, s0_b[LO_W-1:0]}
                 + {{LO_W{1'b0}}, s0_cin};
  assign hi_full = {1'b0, s1_ha} + {1'b0, s1_hb} + {{HI_W{1'b0}}, s1_c};

  // Data registers load only behind a valid bit. This keeps the last stage,
  // and so rsp_sum, holding its value between responses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v_q    <= '0;
      tag_q  <= '0;
      s0_a   <= '0;
      s0_b   <= '0;
      s0_cin <= 1'b0;
      s1_lo  <= '0;
      s1_c   <= 1'b0;
      s1_ha  <= '0;
      s1_hb  <= '0;
      for (int k = 2; k <= LAT; k++) begin
        sum_q[k] <= '0;
      end
      busy   <= 1'b0;
    end else begin
      v_q   <= {v_q[LAT-1:0], acc_any};
      tag_q <= {tag_q[LAT-1:0], acc1};

      if (acc_any) begin
        s0_a   <= acc1 ? req1_a   : req0_a;
        s0_b   <= acc1 ? req1_b   : req0_b;
        s0_cin <= acc1 ? req1_cin : req0_cin;
      end

      if (v_q[0]) begin
        s1_lo <= lo_full[LO_W-1:0];
        s1_c  <= lo_full[LO_W];
        s1_ha <= s0_a[WIDTH-1:LO_W];
        s1_hb <= s0_b[WIDTH-1:LO_W];
      end

      if (v_q[1]) begin
        sum_q[2] <= {hi_full, s1_lo};
      end

      for (int k = 3; k <= LAT; k++) begin
        if (v_q[k-1]) begin
          sum_q[k] <= sum_q[k-1];
        end
      end

      // Mirrors the OR of the valid bits being written this edge.
      busy <= acc_any | (|v_q[LAT-1:0]);
    end
  end

  assign rsp0_valid = v_q[LAT] & ~tag_q[LAT];
  assign rsp1_valid = v_q[LAT] &  tag_q[LAT];
  assign rsp_sum    = sum_q[LAT];

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Testbench for adder_share_arbiter: directed scenarios plus randomized
// traffic. Results are checked against a queue-based reference model.
module tb_adder_share_arbiter;

  localparam int WIDTH = 28;
  localparam int LAT   = 3;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             req0_valid = 1'b0;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a = '0;
  logic [WIDTH-1:0] req0_b = '0;
  logic             req0_cin = 1'b0;
  logic             req1_valid = 1'b0;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a = '0;
  logic [WIDTH-1:0] req1_b = '0;
  logic             req1_cin = 1'b0;
  logic             rsp0_valid;
  logic             rsp1_valid;
  logic [WIDTH:0]   rsp_sum;
  logic             busy;

  adder_share_arbiter #(.WIDTH(WIDTH), .LAT(LAT)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .rsp_sum    (rsp_sum),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           tag;
    logic [WIDTH:0] sum;
    int             due;
  } exp_t;

  exp_t           exp_q[$];
  int             total = 0;
  int             bad = 0;
  int             ecnt = 0;
  logic           favor = 1'b0;
  logic [WIDTH:0] last_sum = '0;

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", tag, obs, exp, ecnt);
    end
  endtask

  // Called just after a rising edge has been counted, at the falling edge.
  task automatic check_outputs();
    exp_t e;
    check_val("busy", busy, exp_q.size() > 0);
    if (exp_q.size() > 0 && exp_q[0].due == ecnt) begin
      e = exp_q.pop_front();
      check_val("rsp0_valid", rsp0_valid, e.tag == 1'b0);
      check_val("rsp1_valid", rsp1_valid, e.tag == 1'b1);
      check_val("rsp_sum", rsp_sum, e.sum);
      last_sum = e.sum;
    end else begin
      check_val("rsp0_idle", rsp0_valid, 0);
      check_val("rsp1_idle", rsp1_valid, 0);
      check_val("rsp_sum_hold", rsp_sum, last_sum);
    end
  endtask

  // One clock cycle. Inputs are driven at the falling edge. Ready is checked
  // against the arbitration rules, and any accepted op is recorded with its
  // due edge. Outputs are then checked after the next rising edge.
  task automatic step(input logic v0, input logic [WIDTH-1:0] a0,
                      input logic [WIDTH-1:0] b0, input logic c0,
                      input logic v1, input logic [WIDTH-1:0] a1,
                      input logic [WIDTH-1:0] b1, input logic c1);
    int   g;
    exp_t e;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = c1;
    #1;
`ifdef ADDARB_FIXED_PRIO_EN
    g = v0 ? 0 : (v1 ? 1 : 0);
`else
    if (v0 && v1) g = int'(favor);
    else if (v0)  g = 0;
    else if (v1)  g = 1;
    else          g = int'(favor);
`endif
    check_val("ready0", req0_ready, g == 0);
    check_val("ready1", req1_ready, g == 1);
    if ((g == 0 && v0) || (g == 1 && v1)) begin
      e.tag = (g == 1);
      if (g == 1) e.sum = {1'b0, a1} + {1'b0, b1} + {{WIDTH{1'b0}}, c1};
      else        e.sum = {1'b0, a0} + {1'b0, b0} + {{WIDTH{1'b0}}, c0};
      e.due = ecnt + 1 + LAT;
      exp_q.push_back(e);
      favor = (g == 0);
    end
    @(posedge clk);
    ecnt++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, 0, '0, '0, 0);
  endtask

  // Single-cycle reset pulse, asserted at a falling edge.
  task automatic reset_pulse();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rstn = 1'b0;
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_rsp0", rsp0_valid, 0);
    check_val("rst_rsp1", rsp1_valid, 0);
    check_val("rst_sum", rsp_sum, 0);
    check_val("rst_ready0", req0_ready, 0);
    check_val("rst_ready1", req1_ready, 0);
    @(posedge clk);
    ecnt++;
    @(negedge clk);
    rstn = 1'b1;
    exp_q.delete();
    favor = 1'b0;
    last_sum = '0;
  endtask

  task automatic rand_step(input int pct);
    logic [31:0] r;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic v0, v1, c0, c1;
    r = $urandom(); a0 = r[WIDTH-1:0];
    r = $urandom(); b0 = r[WIDTH-1:0];
    r = $urandom(); a1 = r[WIDTH-1:0];
    r = $urandom(); b1 = r[WIDTH-1:0];
    r = $urandom();
    if (r[3:0] == 4'd0) a0 = '1;
    if (r[7:4] == 4'd0) b1 = '1;
    c0 = r[8];
    c1 = r[9];
    v0 = ($urandom_range(99) < pct);
    v1 = ($urandom_range(99) < pct);
    step(v0, a0, b0, c0, v1, a1, b1, c1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Idle after reset: requester 0 favoured, nothing in flight.
    idle(2);

    // Carry across the full width.
    step(1, 28'hFFFFFFF, 28'h1, 0, 0, '0, '0, 0);
    idle(LAT + 2);

    // Contention from pointer 0: accepts alternate 0,1,0,1.
    reset_pulse();
    for (int i = 0; i < 4; i++)
      step(1, WIDTH'(100 + i), WIDTH'(7 * i), i[0], 1, WIDTH'(5000 + i), WIDTH'(3), 1);
    idle(LAT + 2);

    // Lone requester 1 streams back-to-back: sums 2i+1.
    for (int i = 0; i < 5; i++)
      step(0, '0, '0, 0, 1, WIDTH'(i), WIDTH'(i), 1);
    idle(LAT + 2);

    // Reset with two ops in flight: they must never come out.
    step(1, WIDTH'(11), WIDTH'(22), 0, 0, '0, '0, 0);
    step(0, '0, '0, 0, 1, WIDTH'(33), WIDTH'(44), 1);
    reset_pulse();
    idle(LAT + 2);
    step(1, WIDTH'(1), WIDTH'(2), 0, 1, WIDTH'(3), WIDTH'(4), 0);
    idle(LAT + 2);

    // Sustained contention, then requester 0 drops out.
    for (int i = 0; i < 3; i++)
      step(1, WIDTH'(200 + i), WIDTH'(1), 0, 1, WIDTH'(300 + i), WIDTH'(2), 0);
    step(0, '0, '0, 0, 1, WIDTH'(400), WIDTH'(5), 1);
    idle(LAT + 2);

    // Randomized traffic with a reset in the middle.
    for (int i = 0; i < 300; i++) rand_step(70);
    reset_pulse();
    for (int i = 0; i < 300; i++) rand_step(40);
    idle(LAT + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
